// File: rtl/wbdepp_pkg.sv
// Shared definitions for the DEPP-to-Wishbone bridge: byte register map,
// STATUS bit positions, FSM state encoding and byte-lane helpers.
package wbdepp_pkg;

  localparam logic [7:0] REG_ADDR0  = 8'd0;
  localparam logic [7:0] REG_ADDR1  = 8'd1;
  localparam logic [7:0] REG_ADDR2  = 8'd2;
  localparam logic [7:0] REG_ADDR3  = 8'd3;
  localparam logic [7:0] REG_DATA0  = 8'd4;
  localparam logic [7:0] REG_DATA1  = 8'd5;
  localparam logic [7:0] REG_DATA2  = 8'd6;
  localparam logic [7:0] REG_DATA3  = 8'd7;
  localparam logic [7:0] REG_STATUS = 8'd8;

  localparam int STAT_BUSY = 0;
  localparam int STAT_ERR  = 1;
  localparam int STAT_INT  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WB_REQ,
    ST_WB_WAIT,
    ST_DONE
  } state_e;

  // Lane 0 is the most significant byte, matching the host's register order.
  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_depp_bridge_sync.sv
// depp_sync: SYNC_STAGES-deep synchronizer for the asynchronous DEPP inputs.
// Strobes and write_n reset to their idle-high level, data resets to zero.
module depp_sync #(
  parameter int STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_astb_n,
  input  logic       i_dstb_n,
  input  logic       i_write_n,
  input  logic [7:0] i_depp,
  output logic       o_astb_n,
  output logic       o_dstb_n,
  output logic       o_write_n,
  output logic [7:0] o_depp
);

  localparam logic [10:0] RST_VAL = 11'b111_0000_0000;

  logic [STAGES-1:0][10:0] stage_q, stage_d;

  always_comb begin
    stage_d[0] = {i_astb_n, i_dstb_n, i_write_n, i_depp};
    for (int i = 1; i < STAGES; i++) stage_d[i] = stage_q[i-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples its pre-edge neighbour.
  always_ff @(posedge i_clk) begin
    if (i_rst) stage_q <= {STAGES{RST_VAL}};
    else       stage_q <= stage_d;
  end

  assign {o_astb_n, o_dstb_n, o_write_n, o_depp} = stage_q[STAGES-1];

endmodule

// File: rtl/wb_depp_bridge.sv
// DEPP 8-bit host port to 32-bit pipelined Wishbone master bridge.
// Build option: define WBDEPP_AUTOINC_EN to post-increment ADDR after every acked cycle.
module wb_depp_bridge
  import wbdepp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WB_TIMEOUT  = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_astb_n,
  input  logic        i_dstb_n,
  input  logic        i_write_n,
  input  logic [7:0]  i_depp,
  output logic [7:0]  o_depp,
  output logic        o_wait,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data,
  input  logic        i_int
);

  localparam int TMO_W = $clog2(WB_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WB_TIMEOUT - 1);

  logic       astb_s, dstb_s, write_n_s;
  logic [7:0] depp_s;

  depp_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_astb_n  (i_astb_n),
    .i_dstb_n  (i_dstb_n),
    .i_write_n (i_write_n),
    .i_depp    (i_depp),
    .o_astb_n  (astb_s),
    .o_dstb_n  (dstb_s),
    .o_write_n (write_n_s),
    .o_depp    (depp_s)
  );

  state_e           state_q, state_d;
  logic [7:0]       sel_q, sel_d, depp_q, depp_d;
  logic [31:0]      addr_q, addr_d, data_q, data_d;
  logic             err_q, err_d, int_q, int_d;
  logic             wait_q, wait_d, cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic             astb_act_q, astb_act_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       rd_byte;

  always_comb begin
    rd_byte = 8'h00;
    case (sel_q)
      REG_ADDR0, REG_ADDR1, REG_ADDR2, REG_ADDR3: rd_byte = get_byte(addr_q, sel_q[1:0]);
      REG_DATA1, REG_DATA2, REG_DATA3:            rd_byte = get_byte(data_q, sel_q[1:0]);
      REG_STATUS: begin
        rd_byte[STAT_BUSY] = cyc_q;
        rd_byte[STAT_ERR]  = err_q;
        rd_byte[STAT_INT]  = int_q;
      end
      default: ;
    endcase
  end

  // NOTE: every _d defaults to its _q first, so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;  sel_d = sel_q;    depp_d = depp_q;
    addr_d  = addr_q;   data_d = data_q;  err_d = err_q;    int_d = int_q;
    wait_d  = wait_q;   cyc_d = cyc_q;    stb_d = stb_q;    we_d = we_q;
    astb_act_d = astb_act_q;
    tmo_d   = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (!astb_s) begin
          astb_act_d = 1'b1;
          state_d    = ST_ADDR;
        end else if (!dstb_s) begin
          astb_act_d = 1'b0;
          state_d    = ST_DATA;
        end
      end
      ST_ADDR: begin
        if (!write_n_s) sel_d  = depp_s;
        else            depp_d = sel_q;
        wait_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DATA: begin
        if (!write_n_s) begin
          if (sel_q <= REG_ADDR3)      addr_d = put_byte(addr_q, sel_q[1:0], depp_s);
          else if (sel_q <= REG_DATA3) data_d = put_byte(data_q, sel_q[1:0], depp_s);
        end
        if ((!write_n_s && sel_q == REG_DATA3) || (write_n_s && sel_q == REG_DATA0)) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = !write_n_s;
          tmo_d   = '0;
          state_d = ST_WB_REQ;
        end else begin
          if (write_n_s) depp_d = rd_byte;
          // Sticky flags clear only after the STATUS byte above has been captured.
          if (write_n_s && sel_q == REG_STATUS) begin
            err_d = 1'b0;
            int_d = 1'b0;
          end
          wait_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WB_REQ, ST_WB_WAIT: begin
        if (tmo_q == TMO_LAST || (state_q == ST_WB_WAIT && i_wb_err)) begin
          err_d = 1'b1;
          if (!we_q) depp_d = 8'h00;
          cyc_d = 1'b0;  stb_d = 1'b0;  we_d = 1'b0;
          wait_d  = 1'b1;
          state_d = ST_DONE;
        end else if (state_q == ST_WB_WAIT && i_wb_ack) begin
          if (!we_q) begin
            data_d = i_wb_data;
            depp_d = i_wb_data[31:24];
          end
`ifdef WBDEPP_AUTOINC_EN
          addr_d = addr_q + 32'd1;
`else
          addr_d = addr_q;
`endif
          cyc_d = 1'b0;  we_d = 1'b0;
          wait_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (state_q == ST_WB_REQ && !i_wb_stall) begin
            stb_d   = 1'b0;
            state_d = ST_WB_WAIT;
          end
        end
      end
      ST_DONE: begin
        if (astb_act_q ? astb_s : dstb_s) begin
          wait_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_int) int_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;  sel_q <= '0;  depp_q <= '0;
      addr_q  <= '0;       data_q <= '0; err_q <= 1'b0;  int_q <= 1'b0;
      wait_q  <= 1'b0;     cyc_q <= 1'b0; stb_q <= 1'b0; we_q <= 1'b0;
      astb_act_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;  sel_q <= sel_d;  depp_q <= depp_d;
      addr_q  <= addr_d;   data_q <= data_d; err_q <= err_d; int_q <= int_d;
      wait_q  <= wait_d;   cyc_q <= cyc_d;   stb_q <= stb_d; we_q <= we_d;
      astb_act_q <= astb_act_d;
      tmo_q   <= tmo_d;
    end
  end

  assign o_depp    = depp_q;
  assign o_wait    = wait_q;
  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = we_q;
  assign o_wb_addr = addr_q;
  assign o_wb_data = data_q;

endmodule

// File: tb/tb_wb_depp_bridge.sv
// Scoreboard bench for wb_depp_bridge: host tasks push expected bytes and
// Wishbone requests from a register-level model; monitors pop and compare.
module tb_wb_depp_bridge;

  localparam int SYNC = 2;
  localparam int TMO  = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        astb_n, dstb_n, write_n, wb_ack, wb_stall, wb_err, irq;
  logic [7:0]  depp_in, depp_out;
  logic        wait_o, wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_addr, wb_wdata, wb_rdata;

  always #5 clk = ~clk;

  wb_depp_bridge dut (
    .i_clk(clk), .i_rst(rst), .i_astb_n(astb_n), .i_dstb_n(dstb_n),
    .i_write_n(write_n), .i_depp(depp_in), .o_depp(depp_out), .o_wait(wait_o),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
    .o_wb_data(wb_wdata), .i_wb_ack(wb_ack), .i_wb_stall(wb_stall),
    .i_wb_err(wb_err), .i_wb_data(wb_rdata), .i_int(irq)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } wb_t;
  wb_t        exp_wb[$];
  logic [7:0] exp_rd[$];

  // Register-level model of the host-visible state.
  logic [7:0]  m_sel;
  logic [31:0] m_addr, m_data;
  bit          m_err, m_int;

  // Slave behaviour: 0 = ack, 1 = err, 2 = never respond.
  int          sl_stall, sl_wait, sl_mode, sl_resp_cnt, cyc_len;
  logic [31:0] sl_rdata;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int idx);
    return 8'((w >> (8 * (3 - idx))) & 32'hFF);
  endfunction

  function automatic logic [31:0] with_byte(input logic [31:0] w, input int idx, input logic [7:0] b);
    int sh;
    sh = 8 * (3 - idx);
    return (w & ~(32'hFF << sh)) | (32'(b) << sh);
  endfunction

  task automatic model_wb(input bit we);
    wb_t t;
    t.we = we; t.addr = m_addr; t.data = m_data;
    exp_wb.push_back(t);
    if (sl_mode == 0) begin
      if (!we) begin
        m_data = sl_rdata;
        exp_rd.push_back(sl_rdata[31:24]);
      end
`ifdef WBDEPP_AUTOINC_EN
      m_addr = m_addr + 1;
`endif
    end else begin
      m_err = 1;
      if (!we) exp_rd.push_back(8'h00);
    end
  endtask

  task automatic model_access(input bit is_addr, input bit wr, input logic [7:0] b, output bit is_wb);
    logic [7:0] rd;
    is_wb = 0;
    if (is_addr) begin
      if (wr) m_sel = b;
      else    exp_rd.push_back(m_sel);
    end else if (wr) begin
      if (m_sel < 4)      m_addr = with_byte(m_addr, m_sel, b);
      else if (m_sel < 8) m_data = with_byte(m_data, m_sel - 4, b);
      if (m_sel == 7) begin is_wb = 1; model_wb(1'b1); end
    end else if (m_sel == 4) begin
      is_wb = 1;
      model_wb(1'b0);
    end else begin
      if (m_sel < 4)       rd = byte_of(m_addr, m_sel);
      else if (m_sel < 8)  rd = byte_of(m_data, m_sel - 4);
      else if (m_sel == 8) rd = {5'd0, m_int, m_err, 1'b0};
      else                 rd = 8'h00;
      exp_rd.push_back(rd);
      if (m_sel == 8) begin m_err = 0; m_int = 0; end
    end
  endtask

  task automatic host(input bit use_a, input bit use_d, input bit wr, input logic [7:0] b);
    bit is_wb;
    int n, resp0;
    model_access(use_a, wr, b, is_wb);
    resp0 = sl_resp_cnt;
    @(negedge clk);
    write_n = !wr; depp_in = b; astb_n = !use_a; dstb_n = !use_d;
    n = 0;
    while (wait_o !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000)         check("wait_rise_timeout", 32'(n), 32'd0);
    else if (!is_wb)       check("wait_latency", 32'(n), 32'(SYNC + 2));
    else if (sl_mode == 2) check("wait_after_timeout", 32'(n >= TMO), 32'd1);
    else                   check("wait_after_response", 32'(sl_resp_cnt != resp0), 32'd1);
    astb_n = 1'b1; dstb_n = 1'b1;
    n = 0;
    while (wait_o !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    check("wait_release", {31'd0, wait_o}, 32'd0);
  endtask

  task automatic pulse_int();
    @(negedge clk); irq = 1'b1;
    @(negedge clk); irq = 1'b0;
    m_int = 1;
  endtask

  // Read-byte monitor: o_depp is compared whenever o_wait rises on a host read.
  initial begin
    logic prev_wait;
    prev_wait = 1'b0;
    forever begin
      @(negedge clk);
      if (wait_o === 1'b1 && !prev_wait && write_n === 1'b1) begin
        if (exp_rd.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
        else                    check("rd_byte", {24'd0, depp_out}, {24'd0, exp_rd.pop_front()});
      end
      prev_wait = (wait_o === 1'b1);
    end
  end

  // Wishbone request monitor and cycle-length tracker.
  initial begin
    logic prev_stb;
    int   cnt;
    wb_t  e;
    prev_stb = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      if (wb_stb === 1'b1 && !prev_stb) begin
        if (exp_wb.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_wb.pop_front();
          check("wb_we", {31'd0, wb_we}, {31'd0, e.we});
          check("wb_addr", wb_addr, e.addr);
          if (e.we) check("wb_data", wb_wdata, e.data);
        end
      end
      prev_stb = (wb_stb === 1'b1);
      if (wb_cyc === 1'b1) cnt++;
      else if (cnt != 0) begin cyc_len = cnt; cnt = 0; end
    end
  end

  // Wishbone slave.
  initial begin
    wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_rdata = '0;
    forever begin
      @(negedge clk);
      if (wb_cyc === 1'b1 && wb_stb === 1'b1) begin
        wb_stall = (sl_stall != 0);
        for (int s = 0; s < sl_stall; s++) @(negedge clk);
        wb_stall = 1'b0;
        @(negedge clk);
        for (int w = 0; w < sl_wait; w++) @(negedge clk);
        if (sl_mode == 0) begin
          wb_ack = 1'b1; wb_rdata = sl_rdata; sl_resp_cnt++;
          @(negedge clk); wb_ack = 1'b0;
        end else if (sl_mode == 1) begin
          wb_err = 1'b1; sl_resp_cnt++;
          @(negedge clk); wb_err = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    rst = 1'b1; astb_n = 1'b1; dstb_n = 1'b1; write_n = 1'b1; depp_in = '0; irq = 1'b0;
    m_sel = '0; m_addr = '0; m_data = '0; m_err = 0; m_int = 0;
    sl_stall = 0; sl_wait = 0; sl_mode = 0; sl_rdata = '0; sl_resp_cnt = 0; cyc_len = 0;
    repeat (4) @(negedge clk);
    check("rst_wait", {31'd0, wait_o}, 32'd0);
    check("rst_cyc", {31'd0, wb_cyc}, 32'd0);
    check("rst_stb", {31'd0, wb_stb}, 32'd0);
    check("rst_we", {31'd0, wb_we}, 32'd0);
    check("rst_depp", {24'd0, depp_out}, 32'd0);
    check("rst_addr", wb_addr, 32'd0);
    check("rst_data", wb_wdata, 32'd0);
    rst = 1'b0;

    // Address register write then read back.
    host(1, 0, 1, 8'h05);
    host(1, 0, 0, 8'h00);

    // Wishbone write of 0xDEADBEEF to 0x10, byte 7 last.
    sl_stall = 0; sl_wait = 2; sl_mode = 0;
    for (int i = 0; i < 8; i++) begin
      host(1, 0, 1, 8'(i));
      host(0, 1, 1, (i < 4) ? byte_of(32'h0000_0010, i) : byte_of(32'hDEAD_BEEF, i - 4));
    end

    // Wishbone read: one stall cycle, three wait cycles.
    sl_stall = 1; sl_wait = 3; sl_rdata = 32'h1234_5678;
    for (int i = 4; i < 8; i++) begin
      host(1, 0, 1, 8'(i));
      host(0, 1, 0, 8'h00);
    end

    // Slave that never responds: timeout, then sticky err read and cleared.
    sl_stall = 0; sl_wait = 0; sl_mode = 2;
    host(1, 0, 1, 8'h04);
    host(0, 1, 0, 8'h00);
    check("timeout_cyc_len", 32'(cyc_len), 32'(TMO));
    host(1, 0, 1, 8'h08);
    host(0, 1, 0, 8'h00);
    host(0, 1, 0, 8'h00);

    // Interrupt, then simultaneous strobes resolve as an address access.
    sl_mode = 0;
    pulse_int();
    host(0, 1, 0, 8'h00);
    host(0, 1, 0, 8'h00);
    host(1, 1, 1, 8'h06);
    host(1, 0, 0, 8'h00);
    host(0, 1, 0, 8'h00);

    // Randomized register traffic with varied slave timing and outcomes.
    for (int k = 0; k < 60; k++) begin
      sl_stall = $urandom_range(0, 2);
      sl_wait  = $urandom_range(0, 3);
      sl_mode  = ($urandom_range(0, 4) == 0) ? 1 : 0;
      sl_rdata = $urandom;
      if ($urandom_range(0, 7) == 0) pulse_int();
      op = $urandom_range(0, 9);
      if (op < 3)       host(1, 0, 1, 8'($urandom_range(0, 10)));
      else if (op == 3) host(1, 0, 0, 8'h00);
      else if (op < 7)  host(0, 1, 1, 8'($urandom));
      else              host(0, 1, 0, 8'h00);
    end

    // Reset during WB_WAIT with an unresponsive slave.
    sl_mode = 2; sl_stall = 0; sl_wait = 0;
    host(1, 0, 1, 8'h04);
    begin
      wb_t t;
      int  n;
      t.we = 1'b0; t.addr = m_addr; t.data = m_data;
      exp_wb.push_back(t);
      @(negedge clk);
      write_n = 1'b1; dstb_n = 1'b0;
      n = 0;
      while (!(wb_cyc === 1'b1 && wb_stb === 1'b0) && n < 50) begin @(negedge clk); n++; end
      check("reach_wb_wait", 32'(n < 50), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_cyc", {31'd0, wb_cyc}, 32'd0);
      check("midrst_stb", {31'd0, wb_stb}, 32'd0);
      check("midrst_wait", {31'd0, wait_o}, 32'd0);
      check("midrst_addr", wb_addr, 32'd0);
      check("midrst_data", wb_wdata, 32'd0);
      dstb_n = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_sel = '0; m_addr = '0; m_data = '0; m_err = 0; m_int = 0;
    end
    sl_mode = 0;
    for (int i = 0; i < 9; i++) begin
      if (i != 4) begin
        host(1, 0, 1, 8'(i));
        host(0, 1, 0, 8'h00);
      end
    end

    repeat (4) @(negedge clk);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    check("wb_queue_empty", 32'(exp_wb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
